// File: rtl/sobel_filter.sv
// sobel_filter: streaming 3x3 Sobel gradient engine over a raster-order grayscale pixel stream.
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset; aborts the current frame
//   in_valid  in_pixel is accepted this cycle (no backpressure)
//   in_sof    start of frame, qualified by in_valid; forces the pixel to (0,0)
//   in_pixel  unsigned grayscale pixel
//   out_valid Gx/Gy valid for one cycle, one cycle after an accepted pixel at row>=2, col>=2
//   Gx, Gy    signed gradients of the window centred at (row-1, col-1); held otherwise
module sobel_filter #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int PIX_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic                 in_sof,
  input  logic [PIX_WIDTH-1:0] in_pixel,
  output logic                 out_valid,
  output logic signed [15:0]   Gx,
  output logic signed [15:0]   Gy
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(IMG_HEIGHT - 1);
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [PIX_WIDTH-1:0] r_lb1 [IMG_WIDTH];
  logic [PIX_WIDTH-1:0] r_lb2 [IMG_WIDTH];
  logic [PIX_WIDTH-1:0] r_win [3][3];
  logic [PIX_WIDTH-1:0] w_win [3][3];
  logic [CW-1:0] w_col;
  logic [RW-1:0] w_row;
  logic [PIX_WIDTH-1:0] w_top, w_mid;
  logic w_emit;
  logic signed [15:0] w_gx, w_gy;
  function automatic logic signed [15:0] ext(input logic [PIX_WIDTH-1:0] v);
    return signed'(16'(v));
  endfunction
  // in_sof overrides the counters so the pixel lands at (0,0)
  assign w_col  = in_sof ? '0 : r_col;
  assign w_row  = in_sof ? '0 : r_row;
  assign w_top  = r_lb2[w_col];
  assign w_mid  = r_lb1[w_col];
  // col>=2 keeps every emitted window inside one line
  assign w_emit = in_valid && (w_row >= RW'(2)) && (w_col >= CW'(2));
  // window as it will be after this pixel shifts in; gradients are taken from it
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_win[i][0] = r_win[i][1];
      w_win[i][1] = r_win[i][2];
    end
    w_win[0][2] = w_top;
    w_win[1][2] = w_mid;
    w_win[2][2] = in_pixel;
  end
  assign w_gx = (ext(w_win[0][2]) + (ext(w_win[1][2]) <<< 1) + ext(w_win[2][2]))
              - (ext(w_win[0][0]) + (ext(w_win[1][0]) <<< 1) + ext(w_win[2][0]));
  assign w_gy = (ext(w_win[2][0]) + (ext(w_win[2][1]) <<< 1) + ext(w_win[2][2]))
              - (ext(w_win[0][0]) + (ext(w_win[0][1]) <<< 1) + ext(w_win[0][2]));
  // storage is left unreset: stale contents never reach an emitted window
  always_ff @(posedge clk) begin
    if (in_valid) begin
      r_lb1[w_col] <= in_pixel;
      r_lb2[w_col] <= w_mid;
      r_win        <= w_win;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col     <= '0;
      r_row     <= '0;
      out_valid <= 1'b0;
      Gx        <= '0;
      Gy        <= '0;
    end else begin
      out_valid <= w_emit;
      if (in_valid) begin
        r_col <= (w_col == LAST_COL) ? '0 : w_col + CW'(1);
        r_row <= (w_col != LAST_COL) ? w_row : (w_row == LAST_ROW) ? '0 : w_row + RW'(1);
      end
      if (w_emit) begin
        Gx <= w_gx;
        Gy <= w_gy;
      end
    end
  end
endmodule

// File: tb/tb_sobel_filter.sv
// tb_sobel_filter: directed-frame bench with a 2-D image reference model checked every cycle.
module tb_sobel_filter;
  localparam int W = 8;
  localparam int H = 6;
  localparam int N = (W - 2) * (H - 2);
  logic clk = 0;
  logic rst_n = 0;
  logic in_valid = 0;
  logic in_sof = 0;
  logic [7:0] in_pixel = 0;
  logic out_valid;
  logic signed [15:0] Gx, Gy;
  int checks = 0;
  int failures = 0;
  int cnt = 0;
  int og [N];
  int oy [N];
  int sg [N];
  int sy [N];
  int rnd [W*H];
  int mimg [H][W];
  sobel_filter #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof),
    .in_pixel(in_pixel), .out_valid(out_valid), .Gx(Gx), .Gy(Gy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  // reference: every accepted pixel is written into a 2-D image at its raster
  // position; a pixel at (r>=2,c>=2) yields the Sobel of the 3x3 block ending there
  initial begin
    int mr, mc, r, c, egx, egy;
    bit eov;
    mr = 0; mc = 0; egx = 0; egy = 0;
    forever begin
      @(posedge clk);
      eov = 0;
      if (!rst_n) begin
        mr = 0; mc = 0; egx = 0; egy = 0;
      end else if (in_valid) begin
        r = in_sof ? 0 : mr;
        c = in_sof ? 0 : mc;
        mimg[r][c] = int'(in_pixel);
        if (r >= 2 && c >= 2) begin
          eov = 1;
          egx = (mimg[r-2][c] + 2*mimg[r-1][c] + mimg[r][c])
              - (mimg[r-2][c-2] + 2*mimg[r-1][c-2] + mimg[r][c-2]);
          egy = (mimg[r][c-2] + 2*mimg[r][c-1] + mimg[r][c])
              - (mimg[r-2][c-2] + 2*mimg[r-2][c-1] + mimg[r-2][c]);
        end
        mc = c + 1;
        mr = r;
        if (mc == W) begin
          mc = 0;
          mr = (r == H - 1) ? 0 : r + 1;
        end
      end
      #1;
      chk("out_valid", int'(out_valid), int'(eov));
      chk("Gx", int'(Gx), egx);
      chk("Gy", int'(Gy), egy);
      if (out_valid) begin
        if (cnt < N) begin
          og[cnt] = int'(Gx);
          oy[cnt] = int'(Gy);
        end
        cnt++;
      end
    end
  end
  function automatic logic [7:0] pix(input int pat, input int idx);
    int r, c;
    r = idx / W;
    c = idx % W;
    case (pat)
      0: return 8'd100;
      1: return (c >= 4) ? 8'd255 : 8'd0;
      2: return (r >= 3) ? 8'd255 : 8'd0;
      default: return 8'(rnd[idx]);
    endcase
  endfunction
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      in_valid = 0;
      in_sof = 1'($urandom_range(1));
      in_pixel = 8'($urandom);
    end
  endtask
  task automatic frame(input int pat, input bit gaps, input bit sof, input int npix);
    for (int i = 0; i < npix; i++) begin
      if (gaps) idle($urandom_range(2));
      @(negedge clk);
      in_valid = 1;
      in_sof = sof && (i == 0);
      in_pixel = pix(pat, i);
    end
    idle(3);
  endtask
  initial begin
    for (int i = 0; i < W*H; i++) rnd[i] = int'($urandom_range(255));
    idle(3);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_Gx", int'(Gx), 0);
    chk("reset_Gy", int'(Gy), 0);
    @(negedge clk);
    rst_n = 1;
    cnt = 0;
    frame(0, 0, 1, W*H);
    chk("flat_count", cnt, 24);
    for (int k = 0; k < N; k++) begin
      chk("flat_gx", og[k], 0);
      chk("flat_gy", oy[k], 0);
    end
    cnt = 0;
    frame(1, 0, 1, W*H);
    chk("vedge_count", cnt, 24);
    for (int k = 0; k < N; k++) begin
      int c;
      c = k % (W - 2) + 1;
      chk("vedge_gx", og[k], (c == 3 || c == 4) ? 1020 : 0);
      chk("vedge_gy", oy[k], 0);
      sg[k] = og[k];
      sy[k] = oy[k];
    end
    cnt = 0;
    frame(1, 1, 1, W*H);
    chk("gaps_count", cnt, 24);
    for (int k = 0; k < N; k++) begin
      chk("gaps_gx", og[k], sg[k]);
      chk("gaps_gy", oy[k], sy[k]);
    end
    cnt = 0;
    frame(2, 0, 1, W*H);
    chk("hedge_count", cnt, 24);
    for (int k = 0; k < N; k++) begin
      int r;
      r = k / (W - 2) + 1;
      chk("hedge_gx", og[k], 0);
      chk("hedge_gy", oy[k], (r == 2 || r == 3) ? 1020 : 0);
    end
    frame(3, 0, 1, 3*W + 6);
    @(negedge clk);
    rst_n = 0;
    in_valid = 1;
    in_pixel = 8'd7;
    cnt = 0;
    idle(2);
    chk("rst_mid_pulses", cnt, 0);
    @(negedge clk);
    rst_n = 1;
    frame(0, 0, 0, W*H);
    chk("rst_frame_count", cnt, 24);
    for (int k = 0; k < N; k++) begin
      chk("rst_frame_gx", og[k], 0);
      chk("rst_frame_gy", oy[k], 0);
    end
    for (int i = 0; i < W*H; i++) rnd[i] = int'($urandom_range(255));
    frame(1, 0, 1, 2*W + 4);
    cnt = 0;
    frame(3, 1, 1, W*H);
    chk("sof_count", cnt, 24);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
